// File: rtl/execute_unit_if.sv
// Bundles the execute unit's operand/opcode request and its result/status
// outputs, so the register set and the execute unit share one connection.
interface execute_unit_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [2:0]       dest;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [2:0]       wb_select;
  logic             wb_load;
  logic             zero;
  logic             negative;
  logic             carry;

  // The requester drives operands and samples results.
  modport master (
    output start, opcode, x, y, dest,
    input  busy, done, result, wb_select, wb_load, zero, negative, carry
  );

  // The execute unit consumes operands and drives results.
  modport slave (
    input  start, opcode, x, y, dest,
    output busy, done, result, wb_select, wb_load, zero, negative, carry
  );
endinterface

// File: rtl/execute_unit.sv
// Multi-cycle execute unit: single-cycle ALU ops and a 16-step shift-add
// multiplier, finishing with a one-cycle write-back pulse to the register set.
module execute_unit #(
  parameter int WIDTH = 16
) (
  input  logic          clock,
  input  logic          reset_n,
  execute_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } opcode_t;

  state_t             state_q, state_d;
  logic [2:0]         opcode_q;
  logic [WIDTH-1:0]   opA_q, opB_q;
  logic [2:0]         dest_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [CW-1:0]      count_q;
  logic [WIDTH-1:0]   result_q;
  logic [2:0]         wbSelect_q;
  logic               zero_q, negative_q, carry_q;

  logic [WIDTH-1:0]   aluResult;
  logic               aluCarry;
  logic [WIDTH:0]     addWide;
  logic [2*WIDTH-1:0] shlWide, shrWide;
  logic [CW-1:0]      shiftAmt;
  logic [WIDTH:0]     mulSumHi;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH-1:0]   finalResult;
  logic               finalCarry;
  logic               accept, mulLast, enterWb;

  assign accept  = (state_q == IDLE) && bus.start;
  assign mulLast = (state_q == MUL) && (count_q == CW'(WIDTH - 1));
  assign enterWb = (state_q == EXEC) || mulLast;

  // State register; reset always lands in IDLE regardless of start.
  always_ff @(posedge clock) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: ALU ops take one EXEC cycle, MUL takes one cycle per multiplier bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.opcode == OP_MUL) ? MUL : EXEC;
      EXEC: state_d = WB;
      MUL:  if (mulLast) state_d = WB;
      WB:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle ALU; shifts use a double-width window so the last bit out lands at a fixed position.
  always_comb begin
    shiftAmt  = opB_q[CW-1:0];
    addWide   = {1'b0, opA_q} + {1'b0, opB_q};
    shlWide   = {{WIDTH{1'b0}}, opA_q} << shiftAmt;
    shrWide   = {opA_q, {WIDTH{1'b0}}} >> shiftAmt;
    aluResult = '0;
    aluCarry  = 1'b0;
    case (opcode_q)
      OP_ADD: begin aluResult = addWide[WIDTH-1:0]; aluCarry = addWide[WIDTH]; end
      OP_SUB: begin aluResult = opA_q - opB_q;      aluCarry = (opA_q < opB_q); end
      OP_AND: aluResult = opA_q & opB_q;
      OP_OR:  aluResult = opA_q | opB_q;
      OP_XOR: aluResult = opA_q ^ opB_q;
      OP_SHL: begin aluResult = shlWide[WIDTH-1:0];       aluCarry = shlWide[WIDTH]; end
      OP_SHR: begin aluResult = shrWide[2*WIDTH-1:WIDTH]; aluCarry = shrWide[WIDTH-1]; end
      default: ;
    endcase
  end

  // One shift-add step: add the multiplicand into the upper half when the low bit is set, then shift right.
  always_comb begin
    mulSumHi = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opA_q} : '0);
    mulNext  = {mulSumHi, prod_q[WIDTH-1:1]};
    if (state_q == MUL) begin
      finalResult = mulNext[WIDTH-1:0];
      finalCarry  = |mulNext[2*WIDTH-1:WIDTH];
    end else begin
      finalResult = aluResult;
      finalCarry  = aluCarry;
    end
  end

  // Operand capture, multiplier iteration and write-back registers.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      opcode_q   <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      dest_q     <= '0;
      prod_q     <= '0;
      count_q    <= '0;
      result_q   <= '0;
      wbSelect_q <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
    end else begin
      if (accept) begin
        opcode_q <= bus.opcode;
        opA_q    <= bus.x;
        opB_q    <= bus.y;
        dest_q   <= bus.dest;
        prod_q   <= {{WIDTH{1'b0}}, bus.y};
        count_q  <= '0;
      end
      if (state_q == MUL) begin
        prod_q  <= mulNext;
        count_q <= count_q + 1'b1;
      end
      if (enterWb) begin
        result_q   <= finalResult;
        wbSelect_q <= dest_q;
        zero_q     <= (finalResult == '0);
        negative_q <= finalResult[WIDTH-1];
        carry_q    <= finalCarry;
      end
    end
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == WB);
  assign bus.wb_load   = (state_q == WB);
  assign bus.result    = result_q;
  assign bus.wb_select = wbSelect_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.carry     = carry_q;
endmodule

// File: tb/tb_execute_unit.sv
// Self-checking bench for execute_unit: directed corner cases followed by
// random operations checked against an arithmetic reference model.
module tb_execute_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   testCount = 0;
  int   failCount = 0;

  execute_unit_if #(.WIDTH(16)) bus ();

  execute_unit #(.WIDTH(16)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clock = ~clock;

  // Counts one comparison and reports it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model returning {carry, result} straight from the operation definitions.
  function automatic logic [16:0] modelOp(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wide;
    logic [15:0] r;
    logic        c;
    int          amt;
    amt = int'(b[3:0]);
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: begin wide = 32'(a) + 32'(b); r = wide[15:0]; c = wide[16]; end
      3'd1: begin r = a - b; c = (a < b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a << amt; c = (amt == 0) ? 1'b0 : a[16 - amt]; end
      3'd6: begin r = a >> amt; c = (amt == 0) ? 1'b0 : a[amt - 1]; end
      default: begin wide = 32'(a) * 32'(b); r = wide[15:0]; c = (wide[31:16] != 0); end
    endcase
    return {c, r};
  endfunction

  // Issues one operation, scrambles the inputs after acceptance and checks every cycle until write-back.
  task automatic applyStimulus(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                               input logic [2:0] dst, input int intrudeAt);
    logic [16:0] exp;
    int          latency;
    int          waitCycles;
    int          extraDone;
    exp = modelOp(op, a, b);
    latency = (op == 3'd7) ? 16 : 1;
    waitCycles = 0;
    while (bus.busy && waitCycles < 50) begin
      @(posedge clock); #1;
      waitCycles++;
    end
    if (waitCycles >= 50) checkOutput("idleTimeout", 32'(bus.busy), 32'd0);
    @(negedge clock);
    bus.start = 1'b1; bus.opcode = op; bus.x = a; bus.y = b; bus.dest = dst;
    @(posedge clock); #1;
    bus.start = 1'b0;
    bus.opcode = 3'($urandom); bus.x = 16'($urandom); bus.y = 16'($urandom); bus.dest = 3'($urandom);
    checkOutput("busyAfterAccept", 32'(bus.busy), 32'd1);
    checkOutput("doneAfterAccept", 32'(bus.done), 32'd0);
    for (int c = 1; c <= latency; c++) begin
      if (c == intrudeAt) begin
        bus.start = 1'b1; bus.opcode = 3'd0; bus.x = 16'($urandom); bus.y = 16'($urandom);
      end
      @(posedge clock); #1;
      bus.start = 1'b0;
      checkOutput("busy", 32'(bus.busy), 32'd1);
      if (c < latency) begin
        checkOutput("doneEarly", 32'(bus.done), 32'd0);
        checkOutput("wbLoadEarly", 32'(bus.wb_load), 32'd0);
      end
    end
    checkOutput("done", 32'(bus.done), 32'd1);
    checkOutput("wbLoad", 32'(bus.wb_load), 32'd1);
    checkOutput("result", 32'(bus.result), 32'(exp[15:0]));
    checkOutput("carry", 32'(bus.carry), 32'(exp[16]));
    checkOutput("zero", 32'(bus.zero), 32'(exp[15:0] == 16'h0));
    checkOutput("negative", 32'(bus.negative), 32'(exp[15]));
    checkOutput("wbSelect", 32'(bus.wb_select), 32'(dst));
    @(posedge clock); #1;
    checkOutput("doneAfterWb", 32'(bus.done), 32'd0);
    checkOutput("busyAfterWb", 32'(bus.busy), 32'd0);
    checkOutput("resultHold", 32'(bus.result), 32'(exp[15:0]));
    checkOutput("wbSelectHold", 32'(bus.wb_select), 32'(dst));
    if (intrudeAt > 0) begin
      extraDone = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clock); #1;
        if (bus.done || bus.busy) extraDone++;
      end
      checkOutput("intrusionNotQueued", 32'(extraDone), 32'd0);
    end
  endtask

  // Verifies every output is cleared by reset.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "Busy"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "Done"}, 32'(bus.done), 32'd0);
    checkOutput({tag, "WbLoad"}, 32'(bus.wb_load), 32'd0);
    checkOutput({tag, "Result"}, 32'(bus.result), 32'd0);
    checkOutput({tag, "WbSelect"}, 32'(bus.wb_select), 32'd0);
    checkOutput({tag, "Flags"}, {29'd0, bus.zero, bus.negative, bus.carry}, 32'd0);
  endtask

  // Main sequence: reset, directed cases, intrusion, abort, then random traffic.
  initial begin
    int pulses;
    bus.start = 1'b0; bus.opcode = '0; bus.x = '0; bus.y = '0; bus.dest = '0;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checkResetOutputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    applyStimulus(3'd0, 16'hFFFF, 16'h0001, 3'd3, 0);
    applyStimulus(3'd1, 16'h0005, 16'h0007, 3'd1, 0);
    applyStimulus(3'd7, 16'h0012, 16'h0034, 3'd7, 0);
    applyStimulus(3'd7, 16'h0100, 16'h0100, 3'd2, 0);
    applyStimulus(3'd5, 16'h8001, 16'h0011, 3'd4, 0);
    applyStimulus(3'd6, 16'h0001, 16'h0000, 3'd5, 0);
    applyStimulus(3'd6, 16'h8000, 16'h000F, 3'd6, 0);

    applyStimulus(3'd7, 16'h1234, 16'h0056, 3'd6, 5);

    @(negedge clock);
    bus.start = 1'b1; bus.opcode = 3'd7; bus.x = 16'h00FF; bus.y = 16'h00FF; bus.dest = 3'd5;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    checkResetOutputs("abort");
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clock); #1;
      if (bus.wb_load || bus.busy) pulses++;
    end
    checkOutput("abortNoWbLoad", 32'(pulses), 32'd0);
    applyStimulus(3'd0, 16'h1234, 16'h4321, 3'd2, 0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [15:0] a, b;
      op = 3'($urandom_range(7, 0));
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 5 == 0) b = a;
      applyStimulus(op, a, b, 3'($urandom), 0);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/execute_unit.md
EXECUTE_UNIT -- requirements
Module: execute_unit

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width; all widths below assume 16.
REQ-002 Port: clock  input  1  single clock domain; all state updates on rising edge.
REQ-003 Port: reset_n  input  1  synchronous, active-low reset.
REQ-004 Port: start  input  1  operands/opcode/dest valid; sampled only in IDLE.
REQ-005 Port: opcode  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR, 111 MUL.
REQ-006 Port: x  input  16  source operand 1, from register set x read port.
REQ-007 Port: y  input  16  source operand 2, from register set y read port.
REQ-008 Port: dest  input  3  destination register index 0-7.
REQ-009 Port: busy  output  1  high in every non-IDLE state.
REQ-010 Port: done  output  1  one-cycle completion pulse.
REQ-011 Port: result  output  16  registered operation result.
REQ-012 Port: wb_select  output  3  destination index, drives register set write select.
REQ-013 Port: wb_load  output  1  register set write strobe; identical timing to done.
REQ-014 Port: zero, negative, carry  output  1 each  status flags.

Function
REQ-015 FSM states IDLE, EXEC, MUL, WB; IDLE->EXEC on accepted start with opcode!=111, IDLE->MUL on accepted start with opcode==111, EXEC->WB, MUL->WB after 16th iteration, WB->IDLE unconditionally.
REQ-016 Start accepted only when state==IDLE and start==1 at a rising edge; x, y, opcode, dest captured at that edge; later input changes have no effect on the operation.
REQ-017 start asserted in EXEC, MUL or WB is ignored and not queued.
REQ-018 Non-MUL latency: done/wb_load high for exactly the cycle following the first edge after acceptance; next start acceptable at the following edge.
REQ-019 MUL: shift-add, one multiplier bit per cycle, 16 cycles; done/wb_load high for the cycle after the 16th edge following acceptance; busy high 17 cycles total.
REQ-020 ADD/SUB: modulo 2^16; carry = carry-out for ADD, borrow (x<y unsigned) for SUB.
REQ-021 AND/OR/XOR: bitwise; carry=0.
REQ-022 SHL/SHR: logical, shift amount y[3:0]; carry = last bit shifted out, 0 when amount is 0.
REQ-023 MUL: result = low 16 bits of unsigned 32-bit product; carry=1 iff high 16 bits nonzero.
REQ-024 zero = (result==0); negative = result[15]; all flags, result, wb_select update only on entry to WB and hold until next WB.
REQ-025 wb_select equals captured dest while wb_load is high and holds afterwards.
REQ-026 done and wb_load low in all states except WB.

Reset
REQ-027 reset_n==0 at a rising edge forces IDLE and busy, done, wb_load, result, wb_select, zero, negative, carry to 0, and clears the MUL iteration counter.
REQ-028 Reset dominates start; reset mid-EXEC or mid-MUL aborts the operation with no wb_load pulse.
REQ-029 First start accepted at the first edge with reset_n==1.

Verification
REQ-030 ADD x=0xFFFF y=0x0001 dest=3 -> one cycle after acceptance: result=0x0000, zero=1, carry=1, negative=0, wb_select=3, wb_load/done high one cycle.
REQ-031 SUB x=0x0005 y=0x0007 -> result=0xFFFE, carry=1, negative=1, zero=0.
REQ-032 MUL x=0x0012 y=0x0034 dest=7 -> busy 17 cycles, result=0x03A8, carry=0; then MUL x=0x0100 y=0x0100 -> result=0x0000, zero=1, carry=1.
REQ-033 SHL x=0x8001 y=0x0011 -> result=0x0002, carry=1; SHR x=0x0001 y=0x0000 -> result=0x0001, carry=0.
REQ-034 Accept MUL, then pulse start with opcode ADD at cycle 5 -> ignored; exactly one done pulse, MUL result produced.
REQ-035 Accept MUL, drive reset_n low at iteration 8 -> next cycle busy=0, all outputs 0, no wb_load pulse; fresh ADD afterwards completes normally.
